// File: rtl/controle_escrita_regs.sv
// Write-back collector for banco_de_registradores: merges ALU and load write
// requests into a small FIFO, drains one bank write per cycle, and flags
// pending writes to the registers currently being read.
module controle_escrita_regs #(
    parameter int unsigned PROF = 4,
    parameter int unsigned LARG = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            descartar,
    input  logic            ulaValido,
    output logic            ulaPronto,
    input  logic [4:0]      ulaRD,
    input  logic [LARG-1:0] ulaDado,
    input  logic            memValido,
    output logic            memPronto,
    input  logic [4:0]      memRD,
    input  logic [LARG-1:0] memDado,
    input  logic [4:0]      RS,
    input  logic [4:0]      RT,
    output logic            regWrite,
    output logic [4:0]      RD,
    output logic [LARG-1:0] dadosEscrita,
    output logic            pendenteRS,
    output logic            pendenteRT,
    output logic            cheio
);

    localparam int unsigned PW = (PROF > 1) ? $clog2(PROF) : 1;
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [4:0]      rd;
        logic [LARG-1:0] dado;
    } entrada_t;

    entrada_t        fila_q [PROF];
    logic [PW-1:0]   lei_q, lei_d;
    logic [PW-1:0]   esc_q, esc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic [4:0]      rd_q, rd_d;
    logic [LARG-1:0] dado_q, dado_d;

    logic [CW-1:0]   livres;
    logic            mem_push, ula_push, pop;
    logic [PW-1:0]   esc_ula;

    // Handshake: memory has priority for the last free slot; flush blocks both.
    always_comb begin
        livres    = CW'(PROF) - cnt_q;
        memPronto = !descartar && (livres != '0);
        ulaPronto = !descartar && ((livres >= CW'(2)) || ((livres == CW'(1)) && !memValido));
        mem_push  = memValido && memPronto && (memRD != '0);
        ula_push  = ulaValido && ulaPronto && (ulaRD != '0);
        pop       = (cnt_q != '0);
        esc_ula   = esc_q + PW'(mem_push);
    end

    // Next-state: pointers, count and the registered bank write port.
    always_comb begin
        lei_d  = lei_q;
        esc_d  = esc_q;
        cnt_d  = cnt_q;
        wr_d   = 1'b0;
        rd_d   = rd_q;
        dado_d = dado_q;
        if (descartar) begin
            lei_d = '0;
            esc_d = '0;
            cnt_d = '0;
        end else begin
            if (pop) begin
                wr_d   = 1'b1;
                rd_d   = fila_q[lei_q].rd;
                dado_d = fila_q[lei_q].dado;
                lei_d  = lei_q + PW'(1);
            end
            esc_d = esc_q + PW'(mem_push) + PW'(ula_push);
            cnt_d = cnt_q + CW'(mem_push) + CW'(ula_push) - CW'(pop);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lei_q  <= '0;
            esc_q  <= '0;
            cnt_q  <= '0;
            wr_q   <= 1'b0;
            rd_q   <= '0;
            dado_q <= '0;
        end else begin
            lei_q  <= lei_d;
            esc_q  <= esc_d;
            cnt_q  <= cnt_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            dado_q <= dado_d;
        end
    end

    // FIFO storage; the mem entry lands ahead of a same-cycle ALU entry.
    always_ff @(posedge clock) begin
        if (!descartar) begin
            if (mem_push) fila_q[esc_q]   <= '{rd: memRD, dado: memDado};
            if (ula_push) fila_q[esc_ula] <= '{rd: ulaRD, dado: ulaDado};
        end
    end

    // Hazard flags: any occupied slot or the live output write targeting RS/RT.
    always_comb begin
        logic [PW-1:0] off;
        logic          hit_rs, hit_rt;
        off    = '0;
        hit_rs = wr_q && (rd_q == RS);
        hit_rt = wr_q && (rd_q == RT);
        for (int i = 0; i < int'(PROF); i++) begin
            off = PW'(i) - lei_q;
            if ({1'b0, off} < cnt_q) begin
                if (fila_q[i].rd == RS) hit_rs = 1'b1;
                if (fila_q[i].rd == RT) hit_rt = 1'b1;
            end
        end
        pendenteRS = hit_rs && (RS != '0);
        pendenteRT = hit_rt && (RT != '0);
    end

    assign regWrite     = wr_q;
    assign RD           = rd_q;
    assign dadosEscrita = dado_q;
    assign cheio        = (cnt_q == CW'(PROF));

endmodule

// File: tb/tb_controle_escrita_regs.sv
// Bench for controle_escrita_regs: scoreboard of accepted writes plus a
// table of fill vectors and directed latency/hazard/flush/reset sequences.
module tb_controle_escrita_regs;

    localparam int unsigned LARG = 32;

    logic            clock = 1'b0;
    logic            reset;
    logic            descartar;
    logic            ulaValido, ulaPronto;
    logic [4:0]      ulaRD;
    logic [LARG-1:0] ulaDado;
    logic            memValido, memPronto;
    logic [4:0]      memRD;
    logic [LARG-1:0] memDado;
    logic [4:0]      RS, RT;
    logic            regWrite;
    logic [4:0]      RD;
    logic [LARG-1:0] dadosEscrita;
    logic            pendenteRS, pendenteRT, cheio;

    controle_escrita_regs #(.PROF(4), .LARG(LARG)) dut (
        .clock(clock), .reset(reset), .descartar(descartar),
        .ulaValido(ulaValido), .ulaPronto(ulaPronto), .ulaRD(ulaRD), .ulaDado(ulaDado),
        .memValido(memValido), .memPronto(memPronto), .memRD(memRD), .memDado(memDado),
        .RS(RS), .RT(RT), .regWrite(regWrite), .RD(RD), .dadosEscrita(dadosEscrita),
        .pendenteRS(pendenteRS), .pendenteRT(pendenteRT), .cheio(cheio)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [4:0]      rd;
        logic [LARG-1:0] d;
    } ent_t;

    typedef struct {
        logic            mv;
        logic [4:0]      mrd;
        logic [LARG-1:0] md;
        logic            uv;
        logic [4:0]      urd;
        logic [LARG-1:0] ud;
        logic            e_memp;
        logic            e_ulap;
        logic            e_cheio;
    } vec_t;

    ent_t sb[$];
    int   passed = 0;
    int   total  = 0;

    task automatic chk(input string nome, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h required %0h", nome, got, exp);
    endtask

    task automatic idle();
        descartar = 1'b0;
        ulaValido = 1'b0; ulaRD = '0; ulaDado = '0;
        memValido = 1'b0; memRD = '0; memDado = '0;
    endtask

    // One clock: record handshakes before the edge, check the bank write after it.
    task automatic tick();
        ent_t e;
        #1;
        if (descartar) sb.delete();
        else begin
            if (memValido && memPronto && memRD != 0) sb.push_back('{rd: memRD, d: memDado});
            if (ulaValido && ulaPronto && ulaRD != 0) sb.push_back('{rd: ulaRD, d: ulaDado});
        end
        @(posedge clock);
        #1;
        if (regWrite) begin
            if (sb.size() == 0) chk("sb_spurious_write", 64'(regWrite), 64'd0);
            else begin
                e = sb.pop_front();
                chk("sb_write", 64'({RD, dadosEscrita}), 64'({e.rd, e.d}));
            end
        end
    endtask

    vec_t tbl [8];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        // Reset held low with random request inputs.
        reset = 1'b0;
        RS = '0; RT = '0;
        idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            ulaValido = 1'($urandom); ulaRD = 5'($urandom); ulaDado = $urandom;
            memValido = 1'($urandom); memRD = 5'($urandom); memDado = $urandom;
            RS = 5'($urandom); RT = 5'($urandom);
            #1;
            chk("rst_regWrite", 64'(regWrite), 64'd0);
            chk("rst_ulaPronto", 64'(ulaPronto), 64'd1);
            chk("rst_memPronto", 64'(memPronto), 64'd1);
            chk("rst_pend", 64'({pendenteRS, pendenteRT}), 64'd0);
        end
        chk("rst_RD_data", 64'({RD, dadosEscrita}), 64'd0);
        @(negedge clock);
        idle();
        RS = '0; RT = '0;
        reset = 1'b1;
        @(posedge clock); #1;

        // Single ALU write: visible at N+1, gone at N+2.
        ulaValido = 1'b1; ulaRD = 5'd5; ulaDado = 32'h1234;
        tick();
        idle();
        chk("single_n", 64'(regWrite), 64'd0);
        tick();
        chk("single_n1", 64'({regWrite, RD, dadosEscrita}), 64'({1'b1, 5'd5, 32'h1234}));
        tick();
        chk("single_n2", 64'(regWrite), 64'd0);

        // Simultaneous: mem entry written before the ALU entry.
        memValido = 1'b1; memRD = 5'd3; memDado = 32'hAA;
        ulaValido = 1'b1; ulaRD = 5'd4; ulaDado = 32'hBB;
        tick();
        idle();
        tick();
        chk("simul_first", 64'({regWrite, RD, dadosEscrita}), 64'({1'b1, 5'd3, 32'hAA}));
        tick();
        chk("simul_second", 64'({regWrite, RD, dadosEscrita}), 64'({1'b1, 5'd4, 32'hBB}));
        tick();

        // Fill table: both sources pushing, then mixed, RD=0 and idle rows.
        tbl[0] = '{1'b1, 5'd1, 32'h101, 1'b1, 5'd2,  32'h202, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 5'd3, 32'h303, 1'b1, 5'd4,  32'h404, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 5'd5, 32'h505, 1'b1, 5'd6,  32'h606, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 5'd7, 32'h707, 1'b1, 5'd8,  32'h808, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 5'd0, 32'h0,   1'b1, 5'd9,  32'h909, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0,   1'b1, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 5'd0, 32'hE0,  1'b1, 5'd0,  32'hE1,  1'b1, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 5'd0, 32'h0,   1'b0, 5'd0,  32'h0,   1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            memValido = tbl[i].mv; memRD = tbl[i].mrd; memDado = tbl[i].md;
            ulaValido = tbl[i].uv; ulaRD = tbl[i].urd; ulaDado = tbl[i].ud;
            #1;
            chk($sformatf("tbl%0d_memPronto", i), 64'(memPronto), 64'(tbl[i].e_memp));
            chk($sformatf("tbl%0d_ulaPronto", i), 64'(ulaPronto), 64'(tbl[i].e_ulap));
            chk($sformatf("tbl%0d_cheio", i), 64'(cheio), 64'(tbl[i].e_cheio));
            tick();
        end
        idle();
        for (int i = 0; i < 6; i++) tick();
        chk("tbl_drained", 64'(sb.size()), 64'd0);

        // Hazard on RS, then drain clears it.
        RS = 5'd7; RT = 5'd8;
        ulaValido = 1'b1; ulaRD = 5'd7; ulaDado = 32'h77;
        tick();
        idle();
        chk("haz_queued_rs", 64'(pendenteRS), 64'd1);
        chk("haz_queued_rt", 64'(pendenteRT), 64'd0);
        tick();
        chk("haz_out_reg", 64'({regWrite, pendenteRS}), 64'({1'b1, 1'b1}));
        tick();
        chk("haz_cleared", 64'(pendenteRS), 64'd0);

        // RD=0 request is accepted and never written.
        RS = '0; RT = '0;
        ulaValido = 1'b1; ulaRD = 5'd0; ulaDado = 32'hDEAD;
        #1;
        chk("rd0_pronto", 64'(ulaPronto), 64'd1);
        tick();
        idle();
        tick();
        chk("rd0_no_write", 64'(regWrite), 64'd0);
        tick();

        // Flush with three entries queued.
        memValido = 1'b1; memRD = 5'd10; memDado = 32'hA0;
        ulaValido = 1'b1; ulaRD = 5'd11; ulaDado = 32'hA1;
        tick();
        memRD = 5'd12; memDado = 32'hA2; ulaRD = 5'd13; ulaDado = 32'hA3;
        tick();
        chk("flush_prep_q3", 64'(sb.size()), 64'd3);
        descartar = 1'b1;
        memRD = 5'd14; ulaRD = 5'd15;
        RS = 5'd12;
        #1;
        chk("flush_pronto", 64'({memPronto, ulaPronto}), 64'd0);
        tick();
        idle();
        chk("flush_wr", 64'(regWrite), 64'd0);
        chk("flush_pend", 64'(pendenteRS), 64'd0);
        for (int i = 0; i < 4; i++) tick();

        // Async reset mid-cycle with three entries queued.
        memValido = 1'b1; memRD = 5'd20; memDado = 32'hB0;
        ulaValido = 1'b1; ulaRD = 5'd21; ulaDado = 32'hB1;
        tick();
        memRD = 5'd22; memDado = 32'hB2; ulaRD = 5'd23; ulaDado = 32'hB3;
        tick();
        idle();
        chk("areset_pre_wr", 64'(regWrite), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("areset_wr", 64'(regWrite), 64'd0);
        sb.delete();
        @(posedge clock); #2;
        reset = 1'b1;
        @(posedge clock); #1;
        for (int i = 0; i < 4; i++) tick();
        chk("areset_no_wr", 64'(regWrite), 64'd0);
        chk("areset_cheio", 64'(cheio), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
